// File: rtl/morse_decoder.sv
// Morse receiver: segments a strobed tone/no-tone stream into dots and dashes and decodes letters A-H.
// Defining MORSE_TIMEOUT_EN adds an idle-strobe timeout that aborts a stalled letter with Error=1.
module morse_decoder #(
    parameter int MAX_SYMBOLS = 4
`ifdef MORSE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 400
`endif
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Clear,
    input  logic       BitIn,
    input  logic       BitValid,
    output logic [2:0] Letter,
    output logic       LetterValid,
    output logic       Error,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    state_t                 state;
    logic [2:0]             run;
    logic [1:0]             zeros;
    logic [2:0]             count;
    logic [MAX_SYMBOLS-1:0] symbols;
    logic                   err_flag;
    logic [3:0]             match;
    logic                   timeout;

    // Symbol i of the letter lives in bit i: dot=0, dash=1. Result is {hit, code}.
    function automatic logic [3:0] match_letter(input logic [2:0]             n,
                                                input logic [MAX_SYMBOLS-1:0] sym);
        logic [7:0] s;
        s = 8'(sym);
        case ({n, s})
            {3'd2, 8'b0000_0010}: match_letter = 4'b1_000; // A .-
            {3'd4, 8'b0000_0001}: match_letter = 4'b1_001; // B -...
            {3'd4, 8'b0000_0101}: match_letter = 4'b1_010; // C -.-.
            {3'd3, 8'b0000_0001}: match_letter = 4'b1_011; // D -..
            {3'd1, 8'b0000_0000}: match_letter = 4'b1_100; // E .
            {3'd4, 8'b0000_0100}: match_letter = 4'b1_101; // F ..-.
            {3'd3, 8'b0000_0011}: match_letter = 4'b1_110; // G --.
            {3'd4, 8'b0000_0000}: match_letter = 4'b1_111; // H ....
            default:              match_letter = 4'b0_000;
        endcase
    endfunction

    function automatic logic [MAX_SYMBOLS-1:0] append_symbol(input logic [MAX_SYMBOLS-1:0] buffer,
                                                             input logic [2:0]             pos,
                                                             input logic                   dash);
        logic [MAX_SYMBOLS-1:0] bit_mask;
        bit_mask = {{(MAX_SYMBOLS-1){1'b0}}, dash} << pos;
        append_symbol = buffer | bit_mask;
    endfunction

    assign match = match_letter(count, symbols);
    assign Busy  = (state != IDLE);

`ifdef MORSE_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Counts clocks since the last strobe, the strobe clock itself being 1.
    logic [TIMEOUT_W-1:0] quiet_cycles;
    logic                 mark_start;
    logic                 gap_done;

    assign mark_start = (state == IDLE) && BitValid && BitIn;
    assign gap_done   = (state == SPACE) && BitValid && !BitIn && (zeros == 2'd2);
    assign timeout    = (state != IDLE) && !BitValid &&
                        (quiet_cycles == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            quiet_cycles <= '0;
        end else if (Clear || timeout || gap_done) begin
            quiet_cycles <= '0;
        end else if (state == IDLE) begin
            quiet_cycles <= mark_start ? TIMEOUT_W'(1) : '0;
        end else if (BitValid) begin
            quiet_cycles <= TIMEOUT_W'(1);
        end else begin
            quiet_cycles <= quiet_cycles + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            run         <= 3'd0;
            zeros       <= 2'd0;
            count       <= 3'd0;
            symbols     <= '0;
            err_flag    <= 1'b0;
            Letter      <= 3'b000;
            LetterValid <= 1'b0;
            Error       <= 1'b0;
        end else begin
            LetterValid <= 1'b0;
            if (Clear) begin
                state    <= IDLE;
                run      <= 3'd0;
                zeros    <= 2'd0;
                count    <= 3'd0;
                symbols  <= '0;
                err_flag <= 1'b0;
                Letter   <= 3'b000;
                Error    <= 1'b0;
            end else if (timeout) begin
                state       <= IDLE;
                run         <= 3'd0;
                zeros       <= 2'd0;
                count       <= 3'd0;
                symbols     <= '0;
                err_flag    <= 1'b0;
                Letter      <= 3'b000;
                Error       <= 1'b1;
                LetterValid <= 1'b1;
            end else if (BitValid) begin
                case (state)
                    IDLE: begin
                        if (BitIn) begin
                            state <= MARK;
                            run   <= 3'd1;
                        end
                    end
                    MARK: begin
                        if (BitIn) begin
                            if (run < 3'd4) begin
                                run <= run + 3'd1;
                            end
                        end else begin
                            // Only exact runs of 1 (dot) and 3 (dash) are symbols.
                            if (run == 3'd1 || run == 3'd3) begin
                                if (count >= 3'(MAX_SYMBOLS)) begin
                                    err_flag <= 1'b1;
                                end else begin
                                    symbols <= append_symbol(symbols, count, (run == 3'd3));
                                    count   <= count + 3'd1;
                                end
                            end else begin
                                err_flag <= 1'b1;
                            end
                            state <= SPACE;
                            zeros <= 2'd1;
                        end
                    end
                    SPACE: begin
                        if (BitIn) begin
                            if (zeros == 2'd2) begin
                                err_flag <= 1'b1;
                            end
                            state <= MARK;
                            run   <= 3'd1;
                        end else if (zeros == 2'd2) begin
                            // Third consecutive zero: letter gap, emit next cycle.
                            LetterValid <= 1'b1;
                            if (err_flag || !match[3]) begin
                                Letter <= 3'b000;
                                Error  <= 1'b1;
                            end else begin
                                Letter <= match[2:0];
                                Error  <= 1'b0;
                            end
                            state    <= IDLE;
                            run      <= 3'd0;
                            zeros    <= 2'd0;
                            count    <= 3'd0;
                            symbols  <= '0;
                            err_flag <= 1'b0;
                        end else begin
                            zeros <= zeros + 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: directed vector table, hand-written corner sequences and
// randomized streams checked against a run-length behavioural model.
module tb_morse_decoder;

`ifdef MORSE_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 400;
`endif

    logic       ClockIn = 1'b0;
    logic       Reset;
    logic       Clear;
    logic       BitIn;
    logic       BitValid;
    logic [2:0] Letter;
    logic       LetterValid;
    logic       Error;
    logic       Busy;

    morse_decoder dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .Clear      (Clear),
        .BitIn      (BitIn),
        .BitValid   (BitValid),
        .Letter     (Letter),
        .LetterValid(LetterValid),
        .Error      (Error),
        .Busy       (Busy)
    );

    typedef struct {
        int       sidx;
        int       delay;
        int       letter;
        int       err;
    } pulse_t;

    typedef struct {
        string pat;
        int    letter;
        int    err;
        int    emit_at;
    } vec_t;

    pulse_t got_q[$];
    pulse_t exp_q[$];
    vec_t   vecs[$];
    bit     stream[$];

    int cycle       = 0;
    int strobe_cnt  = 0;
    int last_strobe = 0;
    int vectors     = 0;
    int miscompares = 0;
    int base;

    always #5 ClockIn = ~ClockIn;

    always @(posedge ClockIn) begin
        cycle++;
        if (BitValid) begin
            strobe_cnt++;
            last_strobe = cycle;
        end
    end

    always @(negedge ClockIn) begin
        if (LetterValid) begin
            pulse_t p;
            p.sidx   = strobe_cnt;
            p.delay  = cycle - last_strobe + 1;
            p.letter = int'(Letter);
            p.err    = int'(Error);
            got_q.push_back(p);
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    function automatic string morse_of(input int code);
        case (code)
            0: return ".-";
            1: return "-...";
            2: return "-.-.";
            3: return "-..";
            4: return ".";
            5: return "..-.";
            6: return "--.";
            default: return "....";
        endcase
    endfunction

    // Encoder stage behaviour: dot = 1, dash = 111, one zero between symbols.
    function automatic string encode(input int code);
        string m;
        string s;
        m = morse_of(code);
        s = "";
        for (int k = 0; k < m.len(); k++) begin
            if (k > 0) s = {s, "0"};
            if (m[k] == ".") s = {s, "1"};
            else             s = {s, "111"};
        end
        return s;
    endfunction

    // Reference model: walks runs of ones and zeros of the strobed stream.
    function automatic void model_stream(input int start);
        string  syms;
        bit     err;
        int     i;
        int     n;
        int     len;
        int     zc;
        pulse_t p;
        syms = "";
        err  = 0;
        i    = 0;
        n    = stream.size();
        while (i < n) begin
            if (!stream[i]) begin
                i++;
                continue;
            end
            len = 0;
            while (i < n && stream[i]) begin
                len++;
                i++;
            end
            if (len == 1 || len == 3) begin
                if (syms.len() >= 4)  err = 1;
                else if (len == 1)    syms = {syms, "."};
                else                  syms = {syms, "-"};
            end else begin
                err = 1;
            end
            zc = 0;
            while (i < n && !stream[i] && zc < 3) begin
                zc++;
                i++;
            end
            if (zc == 3) begin
                p.sidx   = start + i;
                p.delay  = 1;
                p.letter = 0;
                p.err    = 1;
                if (!err) begin
                    for (int c = 0; c < 8; c++) begin
                        if (syms == morse_of(c)) begin
                            p.letter = c;
                            p.err    = 0;
                        end
                    end
                end
                exp_q.push_back(p);
                syms = "";
                err  = 0;
            end else if (zc == 2 && i < n) begin
                err = 1;
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ClockIn);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        BitIn    = b;
        BitValid = 1'b1;
        @(posedge ClockIn);
        #1;
        BitIn    = 1'b0;
        BitValid = 1'b0;
        idle(gap);
    endtask

    task automatic send_pat(input string p);
        for (int k = 0; k < p.len(); k++) send_bit(p[k] == "1", 0);
    endtask

    task automatic compare_pulses(input string tag);
        check({tag, " pulse count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            check($sformatf("%s[%0d] strobe", tag, k), got_q[k].sidx, exp_q[k].sidx);
            check($sformatf("%s[%0d] delay", tag, k), got_q[k].delay, exp_q[k].delay);
            check($sformatf("%s[%0d] letter", tag, k), got_q[k].letter, exp_q[k].letter);
            check($sformatf("%s[%0d] error", tag, k), got_q[k].err, exp_q[k].err);
        end
    endtask

    task automatic add_vec(input string p, input int l, input int e, input int at);
        vec_t v;
        v.pat     = p;
        v.letter  = l;
        v.err     = e;
        v.emit_at = at;
        vecs.push_back(v);
    endtask

    task automatic expect_one(input int sidx, input int dly, input int l, input int e);
        pulse_t p;
        p.sidx   = sidx;
        p.delay  = dly;
        p.letter = l;
        p.err    = e;
        exp_q.push_back(p);
    endtask

    initial begin
        string p;
        Reset    = 1'b0;
        Clear    = 1'b0;
        BitIn    = 1'b0;
        BitValid = 1'b0;
        idle(3);
        check("reset Busy", int'(Busy), 0);
        check("reset LetterValid", int'(LetterValid), 0);
        check("reset Letter", int'(Letter), 0);
        check("reset Error", int'(Error), 0);
        Reset = 1'b1;
        idle(1);

        // Directed table
        add_vec("101110000000", 0, 0, 8);
        for (int c = 0; c < 8; c++) begin
            p = encode(c);
            add_vec({p, "000000000000"}, c, 0, p.len() + 3);
        end
        add_vec("11000", 0, 1, 5);
        add_vec("101010101000", 0, 1, 12);
        add_vec("1111000", 0, 1, 7);
        add_vec("1001000", 0, 1, 7);
        add_vec("0001000", 4, 0, 7);

        for (int v = 0; v < vecs.size(); v++) begin
            got_q.delete();
            exp_q.delete();
            base = strobe_cnt;
            if (vecs[v].emit_at > 0)
                expect_one(base + vecs[v].emit_at, 1, vecs[v].letter, vecs[v].err);
            send_pat(vecs[v].pat);
            idle(4);
            compare_pulses($sformatf("vec%0d", v));
            check($sformatf("vec%0d hold Letter", v), int'(Letter), vecs[v].letter);
            check($sformatf("vec%0d hold Error", v), int'(Error), vecs[v].err);
            check($sformatf("vec%0d Busy", v), int'(Busy), 0);
        end

        // Async reset in the middle of C
        got_q.delete();
        exp_q.delete();
        send_pat("1110");
        check("C partial Busy", int'(Busy), 1);
        #2;
        Reset = 1'b0;
        #1;
        check("async reset Busy", int'(Busy), 0);
        check("async reset LetterValid", int'(LetterValid), 0);
        @(posedge ClockIn);
        #3;
        Reset = 1'b1;
        idle(1);
        base = strobe_cnt;
        expect_one(base + 4, 1, 4, 0);
        send_pat("1000");
        idle(4);
        compare_pulses("after reset E");

        // Clear on the third gap zero of D
        got_q.delete();
        exp_q.delete();
        send_pat("111010100");
        Clear    = 1'b1;
        BitIn    = 1'b0;
        BitValid = 1'b1;
        @(posedge ClockIn);
        #1;
        Clear    = 1'b0;
        BitValid = 1'b0;
        idle(4);
        compare_pulses("clear D");
        check("clear Busy", int'(Busy), 0);
        check("clear Letter", int'(Letter), 0);

        // Randomized streams
        for (int r = 0; r < 4; r++) begin
            stream.delete();
            repeat (30) begin
                if ($urandom_range(0, 9) < 7) begin
                    p = encode(int'($urandom_range(0, 7)));
                    for (int k = 0; k < p.len(); k++) stream.push_back(p[k] == "1");
                    repeat ($urandom_range(3, 5)) stream.push_back(1'b0);
                end else begin
                    repeat ($urandom_range(1, 4)) begin
                        repeat ($urandom_range(1, 5)) stream.push_back(1'b1);
                        repeat ($urandom_range(1, 4)) stream.push_back(1'b0);
                    end
                end
            end
            repeat (3) stream.push_back(1'b0);
            got_q.delete();
            exp_q.delete();
            base = strobe_cnt;
            model_stream(base);
            for (int k = 0; k < stream.size(); k++)
                send_bit(stream[k], int'($urandom_range(0, 2)));
            idle(4);
            compare_pulses($sformatf("rand%0d", r));
        end

        // Stalled letter
        got_q.delete();
        exp_q.delete();
        base = strobe_cnt;
`ifdef MORSE_TIMEOUT_EN
        expect_one(base + 2, TIMEOUT_CYCLES, 0, 1);
        send_pat("10");
        idle(TIMEOUT_CYCLES + 20);
        compare_pulses("timeout");
        check("timeout Busy", int'(Busy), 0);
`else
        send_pat("10");
        idle(1000);
        compare_pulses("no timeout");
        check("stall Busy", int'(Busy), 1);
        Clear = 1'b1;
        idle(1);
        Clear = 1'b0;
        check("stall clear Busy", int'(Busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
